// File: rtl/countdown_timer.sv
// Seconds-resolution countdown timer: a prescaler turns the clock into one-cycle
// second markers, and a loadable seconds counter counts down to an expiry event.
module countdown_timer #(
    parameter int TICKS_PER_SECOND = 2000000,
    parameter int SECONDS_WIDTH    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     isEnabled,
    input  logic                     load,
    input  logic [SECONDS_WIDTH-1:0] loadValue,
    input  logic                     autoReload,
    output logic                     secondMarker,
    output logic [SECONDS_WIDTH-1:0] secondsRemaining,
    output logic                     expired,
    output logic                     running,
    output logic [1:0]               debugState
);
    localparam int COUNT_WIDTH = $clog2(TICKS_PER_SECOND);
    localparam logic [COUNT_WIDTH-1:0] LAST_TICK = COUNT_WIDTH'(TICKS_PER_SECOND - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   prescaler_q, prescaler_d;
    logic [SECONDS_WIDTH-1:0] reload_value_q, reload_value_d;
    logic [SECONDS_WIDTH-1:0] seconds_q, seconds_d;
    logic                     marker_q, marker_d;
    logic                     expired_q, expired_d;
    logic                     running_q, running_d;

    always_comb begin
        state_d        = state_q;
        prescaler_d    = prescaler_q;
        reload_value_d = reload_value_q;
        seconds_d      = seconds_q;
        marker_d       = 1'b0;
        // Expiry stays visible only while parked in DONE; auto-reload expiry is a pulse.
        expired_d      = (state_q == DONE) && expired_q;

        if (load) begin
            seconds_d      = loadValue;
            reload_value_d = loadValue;
            prescaler_d    = '0;
            expired_d      = 1'b0;
            state_d        = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (isEnabled && (seconds_q != '0)) state_d = RUN;
                end
                RUN: begin
                    if (!isEnabled) begin
                        state_d = PAUSED;
                    end else if (prescaler_q == LAST_TICK) begin
                        prescaler_d = '0;
                        marker_d    = 1'b1;
                        if (seconds_q == SECONDS_WIDTH'(1)) begin
                            expired_d = 1'b1;
                            if (autoReload) begin
                                seconds_d = reload_value_q;
                            end else begin
                                seconds_d = '0;
                                state_d   = DONE;
                            end
                        end else begin
                            seconds_d = seconds_q - 1'b1;
                        end
                    end else begin
                        prescaler_d = prescaler_q + 1'b1;
                    end
                end
                PAUSED: begin
                    // Resume edge does not advance the prescaler, matching IDLE -> RUN.
                    if (isEnabled) state_d = RUN;
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            prescaler_q    <= '0;
            reload_value_q <= '0;
            seconds_q      <= '0;
            marker_q       <= 1'b0;
            expired_q      <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            prescaler_q    <= prescaler_d;
            reload_value_q <= reload_value_d;
            seconds_q      <= seconds_d;
            marker_q       <= marker_d;
            expired_q      <= expired_d;
            running_q      <= running_d;
        end
    end

    assign secondMarker     = marker_q;
    assign secondsRemaining = seconds_q;
    assign expired          = expired_q;
    assign running          = running_q;
    assign debugState       = state_q;
endmodule
